// File: rtl/motor_pwm_bank.sv
// N-channel PWM bank driving H-bridge enables. It supports period-aligned duty updates,
// slew-limited ramping toward per-channel targets, and a sticky overcurrent shutdown.
module motor_pwm_bank #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 12,
  parameter int PERIOD    = 4095,
  parameter int RAMP_STEP = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      duty_load,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      oc,
  input  logic                      fault_clr,
  output logic [CHANNELS-1:0]       pulse,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       ramping,
  output logic                      fault
);

  localparam logic [WIDTH-1:0] PERIOD_V = WIDTH'(PERIOD);
  localparam logic [WIDTH:0]   STEP_V   = (WIDTH+1)'(RAMP_STEP);

  logic [WIDTH-1:0] cnt;
  logic             cnt_at_end;
  logic [WIDTH-1:0] target     [CHANNELS];
  logic [WIDTH-1:0] target_nxt [CHANNELS];
  logic [WIDTH-1:0] active     [CHANNELS];
  logic [WIDTH-1:0] active_nxt [CHANNELS];
  logic             oc_meta;
  logic             oc_s;

  assign cnt_at_end = (cnt == PERIOD_V);

  // Step act toward tgt by at most RAMP_STEP.
  // The extra bit keeps the add and subtract from wrapping.
  function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] act,
                                                    input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] a;
    logic [WIDTH:0] t;
    logic [WIDTH:0] d;
    logic [WIDTH:0] r;
    a = {1'b0, act};
    t = {1'b0, tgt};
    if (t >= a) begin
      d = t - a;
      if (d > STEP_V) d = STEP_V;
      r = a + d;
    end else begin
      d = a - t;
      if (d > STEP_V) d = STEP_V;
      r = a - d;
    end
    return WIDTH'(r);
  endfunction

  // duty_load is a single-cycle strobe with no back-pressure.
  // Every strobe is captured, and a load on the terminal count feeds that same ramp step.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      target_nxt[i] = target[i];
      if (duty_load) begin
        if (duty_in[i*WIDTH +: WIDTH] > PERIOD_V) target_nxt[i] = PERIOD_V;
        else                                      target_nxt[i] = duty_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      active_nxt[i] = active[i];
      if (fault || !enable[i]) begin
        active_nxt[i] = '0;
      end else if (cnt_at_end) begin
        active_nxt[i] = (RAMP_STEP == 0) ? target_nxt[i] : ramp_toward(active[i], target_nxt[i]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ramping[i] = (active[i] != target[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_at_end ? '0 : cnt + 1'b1;
      period_start <= (cnt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= '0;
        active[i] <= '0;
      end
      pulse <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= target_nxt[i];
        active[i] <= active_nxt[i];
        pulse[i]  <= enable[i] & ~fault & ((active[i] == PERIOD_V) | (cnt < active[i]));
      end
    end
  end

  // A synchronised overcurrent condition wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_meta <= 1'b0;
      oc_s    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      oc_meta <= oc;
      oc_s    <= oc_meta;
      if (oc_s)           fault <= 1'b1;
      else if (fault_clr) fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_motor_pwm_bank.sv
// Bench for motor_pwm_bank. It runs two instances on shared inputs: u_a jumps straight
// to the target (RAMP_STEP 0) and u_b ramps in steps of 10.
module tb_motor_pwm_bank;

  localparam int W  = 8;
  localparam int P  = 99;
  localparam int CH = 2;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [CH*W-1:0] duty_in = '0;
  logic          duty_load = 1'b0;
  logic [CH-1:0] enable    = '0;
  logic          oc        = 1'b0;
  logic          fault_clr = 1'b0;
  logic [CH-1:0] pulse_a, pulse_b, ramp_a, ramp_b;
  logic          ps_a, ps_b, fault_a, fault_b;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  motor_pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PERIOD(P), .RAMP_STEP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .duty_load(duty_load), .enable(enable),
    .oc(oc), .fault_clr(fault_clr), .pulse(pulse_a), .period_start(ps_a),
    .ramping(ramp_a), .fault(fault_a)
  );

  motor_pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PERIOD(P), .RAMP_STEP(10)) u_b (
    .clk(clk), .rst_n(rst_n), .duty_in(duty_in), .duty_load(duty_load), .enable(enable),
    .oc(oc), .fault_clr(fault_clr), .pulse(pulse_b), .period_start(ps_b),
    .ramping(ramp_b), .fault(fault_b)
  );

  // ---------------- reference model ----------------
  function automatic int clamp_duty(input logic [W-1:0] d);
    if (int'(d) > P) return P;
    return int'(d);
  endfunction

  function automatic int next_tgt(input logic ld, input logic [W-1:0] d, input int cur);
    return ld ? clamp_duty(d) : cur;
  endfunction

  function automatic int ramp_to(input int act, input int tgt, input int step);
    int d;
    if (step == 0) return tgt;
    d = tgt - act;
    if (d > step)  d = step;
    if (d < -step) d = -step;
    return act + d;
  endfunction

  function automatic int step_of(input int k);
    return (k == 0) ? 0 : 10;
  endfunction

  int            m_cnt;
  int            m_tgt [CH];
  int            m_act [2][CH];
  logic          m_oc1, m_oc2, m_fault;
  logic [CH-1:0] e_pulse [2];
  logic [CH-1:0] e_ramp  [2];
  logic          e_ps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_oc1   <= 1'b0;
      m_oc2   <= 1'b0;
      m_fault <= 1'b0;
      e_ps    <= 1'b0;
      for (int i = 0; i < CH; i++) m_tgt[i] <= 0;
      for (int k = 0; k < 2; k++) begin
        e_pulse[k] <= '0;
        for (int i = 0; i < CH; i++) m_act[k][i] <= 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        m_tgt[i] <= next_tgt(duty_load, duty_in[i*W +: W], m_tgt[i]);
        for (int k = 0; k < 2; k++) begin
          e_pulse[k][i] <= enable[i] && !m_fault && (m_act[k][i] == P || m_cnt < m_act[k][i]);
          if (m_fault || !enable[i]) m_act[k][i] <= 0;
          else if (m_cnt == P)
            m_act[k][i] <= ramp_to(m_act[k][i], next_tgt(duty_load, duty_in[i*W +: W], m_tgt[i]),
                                   step_of(k));
        end
      end
      e_ps  <= (m_cnt == 0);
      m_oc1 <= oc;
      m_oc2 <= m_oc1;
      if (m_oc2)          m_fault <= 1'b1;
      else if (fault_clr) m_fault <= 1'b0;
      m_cnt <= (m_cnt == P) ? 0 : m_cnt + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < CH; i++)
        e_ramp[k][i] = (m_act[k][i] != m_tgt[i]);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    duty_load = 1'b0;
    oc        = 1'b0;
    fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_duty(input logic [W-1:0] d0, input logic [W-1:0] d1);
    @(negedge clk);
    duty_in   = {d1, d0};
    duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
  endtask

  task automatic wait_ps(output bit found);
    found = 1'b0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (ps_a === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Count the high cycles of one whole period of instance k, channel ch.
  // A negative count means no period start was seen.
  task automatic measure_period(input int k, input int ch, input int load_at,
                                input logic [W-1:0] load_val,
                                output int hi, output bit shape_ok, output logic rmp);
    bit   found;
    bit   seen_low;
    logic b;
    wait_ps(found);
    hi       = found ? 0 : -1;
    shape_ok = found;
    rmp      = 1'bx;
    seen_low = 1'b0;
    if (found) begin
      for (int j = 0; j <= P; j++) begin
        if (j > 0) @(negedge clk);
        b = (k == 0) ? pulse_a[ch] : pulse_b[ch];
        if (j == 0) rmp = (k == 0) ? ramp_a[ch] : ramp_b[ch];
        if (b === 1'b1) begin
          hi++;
          if (seen_low) shape_ok = 1'b0;
        end else begin
          seen_low = 1'b1;
        end
        if (j == load_at) begin
          duty_in   = {load_val, load_val};
          duty_load = 1'b1;
        end else begin
          duty_load = 1'b0;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] obs;
    @(negedge clk);
    rst_n     = 1'b0;
    enable    = '0;
    duty_in   = '0;
    duty_load = 1'b0;
    oc        = 1'b0;
    fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    obs = {pulse_a, pulse_b, ps_a, ps_b, ramp_a, ramp_b, fault_a, fault_b};
    n_checks++;
    if (obs !== 12'd0) $display("FAIL reset_outputs: got %b want all zero", obs);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ps_a, ps_b} !== 2'b11) $display("FAIL first_period_start: got %b want 11", {ps_a, ps_b});
    else n_pass++;
  endtask

  task automatic test_duty_25();
    int   hi, d;
    bit   shape, found;
    logic r;
    enable = 2'b11;
    load_duty(8'd25, 8'd25);
    measure_period(0, 0, -1, '0, hi, shape, r);
    n_checks++;
    if (hi != 25 || !shape) $display("FAIL duty25_ch0: got %0d high (shape %0d) want 25 (1)", hi, shape);
    else n_pass++;
    measure_period(0, 1, -1, '0, hi, shape, r);
    n_checks++;
    if (hi != 25 || !shape) $display("FAIL duty25_ch1: got %0d high (shape %0d) want 25 (1)", hi, shape);
    else n_pass++;
    wait_ps(found);
    d = 0;
    if (found) begin
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        d++;
        if (ps_a === 1'b1) break;
      end
    end
    n_checks++;
    if (d != P + 1) $display("FAIL period_spacing: got %0d want %0d", d, P + 1);
    else n_pass++;
  endtask

  task automatic test_extremes();
    int   hi;
    bit   shape;
    logic r;
    load_duty(8'd0, 8'd0);
    measure_period(0, 0, -1, '0, hi, shape, r);
    n_checks++;
    if (hi != 0) $display("FAIL duty0: got %0d high want 0", hi);
    else n_pass++;
    load_duty(8'd99, 8'd99);
    for (int n = 0; n < 2; n++) begin
      measure_period(0, 0, -1, '0, hi, shape, r);
      n_checks++;
      if (hi != P + 1) $display("FAIL duty_full period %0d: got %0d high want %0d", n, hi, P + 1);
      else n_pass++;
    end
    load_duty(8'd200, 8'd200);
    measure_period(0, 0, -1, '0, hi, shape, r);
    n_checks++;
    if (hi != P + 1 || r !== 1'b0)
      $display("FAIL duty_clamp: got %0d high ramping %b want %0d high ramping 0", hi, r, P + 1);
    else n_pass++;
  endtask

  task automatic test_ramp();
    int           hi, a;
    bit           shape;
    logic         r;
    logic [W-1:0] e;
    do_reset();
    enable = 2'b11;
    load_duty(8'd35, 8'd35);
    a = 0;
    while (a != 35) begin
      a = ramp_to(a, 35, 10);
      exp_q.push_back(W'(a));
    end
    a = 35;
    while (a != 5) begin
      a = ramp_to(a, 5, 10);
      exp_q.push_back(W'(a));
    end
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      measure_period(1, 0, -1, '0, hi, shape, r);
      n_checks++;
      if (hi != int'(e) || r !== ((e != 8'd35) && (e != 8'd5)))
        $display("FAIL ramp period %0d: got %0d high ramping %b want %0d", n, hi, r, e);
      else n_pass++;
      if (e == 8'd35) begin
        load_duty(8'd5, 8'd5);
      end
    end
  endtask

  task automatic test_mid_load();
    int   hi;
    bit   shape;
    logic r;
    do_reset();
    enable = 2'b11;
    load_duty(8'd20, 8'd20);
    measure_period(0, 0, -1, '0, hi, shape, r);
    n_checks++;
    if (hi != 20) $display("FAIL midload_before: got %0d high want 20", hi);
    else n_pass++;
    measure_period(0, 0, 39, 8'd60, hi, shape, r);
    n_checks++;
    if (hi != 20 || !shape) $display("FAIL midload_same_period: got %0d high want 20", hi);
    else n_pass++;
    measure_period(0, 0, -1, '0, hi, shape, r);
    n_checks++;
    if (hi != 60 || !shape) $display("FAIL midload_next_period: got %0d high want 60", hi);
    else n_pass++;
  endtask

  task automatic test_overcurrent();
    int   hi, lat, a;
    bit   shape, found;
    logic r;
    do_reset();
    enable = 2'b11;
    load_duty(8'd50, 8'd50);
    measure_period(0, 0, -1, '0, hi, shape, r);
    wait_ps(found);
    oc  = 1'b1;
    lat = 0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (lat == 0 && {pulse_a, pulse_b} === 4'b0000) lat = t;
      if (t == 4) fault_clr = 1'b1;
      if (t == 5) fault_clr = 1'b0;
      if (t == 6) oc = 1'b0;
    end
    n_checks++;
    if (lat < 1 || lat > 4) $display("FAIL oc_latency: got %0d cycles want 1..4", lat);
    else n_pass++;
    n_checks++;
    if ({fault_a, fault_b} !== 2'b11) $display("FAIL oc_clear_ignored: got fault %b want 11", {fault_a, fault_b});
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({pulse_a, pulse_b, fault_a, fault_b} !== 6'b000011)
      $display("FAIL oc_sticky: got %b want 000011", {pulse_a, pulse_b, fault_a, fault_b});
    else n_pass++;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    n_checks++;
    if ({fault_a, fault_b} !== 2'b00) $display("FAIL fault_clear: got %b want 00", {fault_a, fault_b});
    else n_pass++;
    a = 0;
    for (int n = 0; n < 2; n++) begin
      a = ramp_to(a, 50, 10);
      measure_period(1, 0, -1, '0, hi, shape, r);
      n_checks++;
      if (hi != a) $display("FAIL oc_restart period %0d: got %0d high want %0d", n, hi, a);
      else n_pass++;
    end
  endtask

  task automatic test_disable_and_reset();
    int          hi, a;
    bit          shape, found;
    logic        r;
    logic [11:0] obs;
    do_reset();
    enable = 2'b11;
    load_duty(8'd50, 8'd50);
    measure_period(0, 0, -1, '0, hi, shape, r);
    wait_ps(found);
    repeat (10) @(negedge clk);
    enable = 2'b01;
    @(negedge clk);
    n_checks++;
    if (pulse_a !== 2'b01) $display("FAIL disable_ch1: got %b want 01", pulse_a);
    else n_pass++;
    measure_period(0, 0, -1, '0, hi, shape, r);
    n_checks++;
    if (hi != 50) $display("FAIL ch0_unaffected: got %0d high want 50", hi);
    else n_pass++;
    @(negedge clk);
    enable = 2'b11;
    a = 0;
    for (int n = 0; n < 2; n++) begin
      a = ramp_to(a, 50, 10);
      measure_period(1, 1, -1, '0, hi, shape, r);
      n_checks++;
      if (hi != a) $display("FAIL reenable_ch1 period %0d: got %0d high want %0d", n, hi, a);
      else n_pass++;
    end
    wait_ps(found);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {pulse_a, pulse_b, ps_a, ps_b, ramp_a, ramp_b, fault_a, fault_b};
    n_checks++;
    if (obs !== 12'd0) $display("FAIL reset_mid_run: got %b want all zero", obs);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [11:0] obs, exp_v;
    int          oc_left;
    do_reset();
    enable  = 2'b11;
    oc_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      obs   = {pulse_a, pulse_b, ps_a, ps_b, ramp_a, ramp_b, fault_a, fault_b};
      exp_v = {e_pulse[0], e_pulse[1], e_ps, e_ps, e_ramp[0], e_ramp[1], m_fault, m_fault};
      n_checks++;
      if (obs !== exp_v) $display("FAIL random cycle %0d: got %b want %b", c, obs, exp_v);
      else n_pass++;
      duty_in   = {W'($urandom_range(0, 150)), W'($urandom_range(0, 150))};
      duty_load = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) enable = enable ^ CH'(1 << $urandom_range(0, CH - 1));
      if (oc_left > 0) oc_left--;
      else if ($urandom_range(0, 399) == 0) oc_left = $urandom_range(1, 5);
      oc        = (oc_left != 0);
      fault_clr = ($urandom_range(0, 59) == 0);
    end
    duty_load = 1'b0;
    oc        = 1'b0;
    fault_clr = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_duty_25();
    test_extremes();
    test_ramp();
    test_mid_load();
    test_overcurrent();
    test_disable_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
